// File: rtl/multi_channel_timer.sv
// Multi-channel terminal-count timer: per-channel periodic/one-shot counters with one-cycle ticks.
// Define PRESCALE_EN to gate all channel counting with a shared prescaler strobe.
`timescale 1ns/1ps

// state | meaning
// IDLE  | count held at 0, no tick, waiting for start
// RUN   | counting enabled cycles up to the terminal value
module multi_channel_timer #(
   parameter int WIDTH    = 24,
   parameter int NUM_CH   = 4,
   parameter int PRESCALE = 12
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       oneshot,
   input  logic [NUM_CH*WIDTH-1:0] num,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       busy,
   output logic                    any_tick
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state [NUM_CH];
   logic [WIDTH-1:0]  count [NUM_CH];
   logic [NUM_CH-1:0] adv;
   logic [NUM_CH-1:0] match;
   logic [NUM_CH-1:0] tick_nxt;
   logic              strobe;

`ifdef PRESCALE_EN
   localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   logic [PW-1:0] pre_cnt;

   // free-running; start does not realign the prescaler phase
   assign strobe = (pre_cnt == PW'(PRESCALE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else if (strobe) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end
`else
   assign strobe = 1'b1;
`endif

   always_comb begin
      adv      = '0;
      match    = '0;
      tick_nxt = '0;
      busy     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         adv[i]      = en[i] & strobe;
         match[i]    = (count[i] == num[i*WIDTH +: WIDTH]);
         // stop and start both override a coincident terminal match
         tick_nxt[i] = !stop[i] && !start[i] && (state[i] == RUN) && adv[i] && match[i];
         busy[i]     = (state[i] == RUN);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= IDLE;
            count[i] <= '0;
         end
         tick     <= '0;
         any_tick <= 1'b0;
      end else begin
         tick     <= tick_nxt;
         any_tick <= |tick_nxt;
         for (int i = 0; i < NUM_CH; i++) begin
            if (stop[i]) begin
               state[i] <= IDLE;
               count[i] <= '0;
            end else if (start[i]) begin
               state[i] <= RUN;
               count[i] <= '0;
            end else if ((state[i] == RUN) && adv[i]) begin
               if (match[i]) begin
                  count[i] <= '0;
                  if (oneshot[i]) begin
                     state[i] <= IDLE;
                  end
               end else begin
                  count[i] <= count[i] + WIDTH'(1);
               end
            end
         end
      end
   end

endmodule
